uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 12000, SHALL set the inter-byte timeout in CLK cycles (1 ms at 12 MHz); legal range is 2 or more.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 RX_VALID  input  1  SHALL mark a received byte; each CLK cycle with RX_VALID=1 SHALL count as one byte.
REQ-005 RX_DATA  input  8  SHALL carry the received byte; sampled only when RX_VALID=1.
REQ-006 WR_EN  output  1  SHALL be a one-cycle register-write strobe.
REQ-007 WR_ADDR  output  4  SHALL carry the write address; valid while WR_EN=1.
REQ-008 WR_DATA  output  8  SHALL carry the write data; valid while WR_EN=1.
REQ-009 ERR  output  1  SHALL be a one-cycle frame-error pulse.
REQ-010 BUSY  output  1  SHALL be 1 whenever a frame is in progress (state not IDLE).
REQ-011 FRAME_CNT  output  8  SHALL count good frames.
REQ-012 ERR_CNT  output  8  SHALL count frame errors.

Function
REQ-013 The frame format SHALL be 4 bytes: SYNC=0xA5, ADDR, DATA, CSUM.
REQ-014 ADDR[7:4] SHALL be 0 for a valid frame.
REQ-015 CSUM SHALL equal (ADDR + DATA) mod 256, computed at 8-bit width with the carry discarded.
REQ-016 The FSM SHALL have exactly these states: IDLE, ADDR, DATA, CSUM.
REQ-017 IDLE: a byte 0xA5 SHALL move to ADDR; any other byte SHALL be ignored silently, with no ERR and no counter change.
REQ-018 ADDR: a byte with bit[7:4]==0 SHALL be latched and the FSM SHALL move to DATA; otherwise the FSM SHALL raise an error (REQ-022) and go to IDLE. A 0xA5 byte here is an address error, not a resync.
REQ-019 DATA: any byte SHALL be latched and the FSM SHALL move to CSUM.
REQ-020 CSUM, on a match:
  - FSM -> IDLE;
  - WR_EN=1 for exactly the cycle after the RX_VALID cycle, with WR_ADDR/WR_DATA driven from the latched values;
  - FRAME_CNT increments by 1, wrapping 255->0.
REQ-021 CSUM on a mismatch SHALL raise an error (REQ-022) and return the FSM to IDLE, with no WR_EN.
REQ-022 An error SHALL:
  - pulse ERR=1 for exactly the cycle after the detecting edge;
  - increment ERR_CNT, saturating at 255 (no wrap).
REQ-023 The timeout counter SHALL clear to 0 on every RX_VALID and whenever the FSM is in IDLE.
REQ-024 In ADDR, DATA and CSUM, the timeout counter SHALL increment every cycle without RX_VALID.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES-1 without RX_VALID, the FSM SHALL raise an error (REQ-022) and go to IDLE.
REQ-026 If RX_VALID coincides with the timeout-expiry cycle, the byte SHALL be processed and the timeout SHALL NOT fire.
REQ-027 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES) bits, and it SHALL never wrap.
REQ-028 BUSY SHALL be a registered decode of the state: 1 in ADDR, DATA and CSUM, 0 in IDLE.
REQ-029 WR_EN and ERR SHALL never both be 1 in the same cycle.
REQ-030 WR_ADDR and WR_DATA SHALL hold their last values when WR_EN=0.
REQ-031 Back-to-back bytes (RX_VALID on consecutive cycles) SHALL be accepted without loss.
REQ-032 A SYNC byte arriving on the cycle after a completed frame SHALL start a new frame.

Reset
REQ-033 While RST=1, asynchronously and independent of CLK:
  - FSM -> IDLE; timeout counter = 0;
  - WR_EN=0, ERR=0, BUSY=0;
  - WR_ADDR=0, WR_DATA=0;
  - FRAME_CNT=0, ERR_CNT=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame with no ERR pulse and no counter change.
REQ-035 After RST deasserts, the first RX_VALID SHALL be processed normally.

Verification
REQ-036 Good frame: bytes A5,03,5C,5F on consecutive cycles -> one WR_EN pulse with WR_ADDR=3, WR_DATA=0x5C; FRAME_CNT=1; ERR never 1.
REQ-037 Bad checksum: A5,01,FF,FF -> ERR pulse, ERR_CNT=1, no WR_EN, BUSY=0 afterwards.
REQ-038 Checksum wrap: A5,0F,F2,01 -> WR_EN, WR_ADDR=0xF, WR_DATA=0xF2.
REQ-039 Address error and noise:
  - 00,12,A5,A5 -> 00 and 12 are ignored, the first A5 starts a frame, the second A5 gives an ADDR error (ERR_CNT=1);
  - the next byte is then handled in IDLE.
REQ-040 Timeout, with TIMEOUT_CYCLES=16:
  - A5 then silence -> ERR exactly 16 cycles after the A5 cycle, then BUSY=0;
  - repeat with a byte arriving on the expiry cycle -> no ERR.
REQ-041 Saturation and reset:
  - 300 bad frames -> ERR_CNT=255;
  - 256 good frames -> FRAME_CNT=0;
  - RST pulsed between DATA and CSUM bytes -> all outputs 0, no ERR pulse.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Byte-stream command decoder: turns 4-byte frames (A5, ADDR, DATA, CSUM) into
// register write strobes, with an inter-byte timeout and good/error frame counters.
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_VALID,
  input  logic [7:0] RX_DATA,
  output logic       WR_EN,
  output logic [3:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       ERR,
  output logic       BUSY,
  output logic [7:0] FRAME_CNT,
  output logic [7:0] ERR_CNT,
  output logic [1:0] DBG_STATE
);

  // RX_VALID is a push-only valid with no ready: every cycle it is high one
  // byte is consumed and must be handled, there is no backpressure.

  localparam int              TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      SYNC   = 8'hA5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_CSUM = 2'd3;

  logic [1:0]    state, state_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [3:0]    addr_q;
  logic [7:0]    data_q;
  logic [7:0]    csum_exp;
  logic          wr_d, err_d, timeout, latch_addr, latch_data;

  assign csum_exp  = {4'b0000, addr_q} + data_q;
  assign DBG_STATE = state;

  always_comb begin
    state_d    = state;
    wr_d       = 1'b0;
    err_d      = 1'b0;
    latch_addr = 1'b0;
    latch_data = 1'b0;
    // A byte arriving on the expiry cycle wins over the timeout.
    timeout    = (state != S_IDLE) && !RX_VALID && (tcnt == T_LAST);
    case (state)
      S_IDLE: if (RX_VALID && RX_DATA == SYNC) state_d = S_ADDR;
      S_ADDR: if (RX_VALID) begin
        if (RX_DATA[7:4] == 4'h0) begin
          latch_addr = 1'b1;
          state_d    = S_DATA;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DATA: if (RX_VALID) begin
        latch_data = 1'b1;
        state_d    = S_CSUM;
      end
      S_CSUM: if (RX_VALID) begin
        if (RX_DATA == csum_exp) wr_d  = 1'b1;
        else                     err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
    if (state == S_IDLE || RX_VALID || timeout) tcnt_d = '0;
    else                                          tcnt_d = tcnt + TW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      WR_EN     <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
      FRAME_CNT <= '0;
      ERR_CNT   <= '0;
    end else begin
      state <= state_d;
      tcnt  <= tcnt_d;
      WR_EN <= wr_d;
      ERR   <= err_d;
      BUSY  <= (state_d != S_IDLE);
      if (latch_addr) addr_q <= RX_DATA[3:0];
      if (latch_data) data_q <= RX_DATA;
      if (wr_d) begin
        WR_ADDR   <= addr_q;
        WR_DATA   <= data_q;
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
      if (err_d && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame vector table, scoreboard of expected
// writes, and hand sequences for timeout, back-to-back, reset and saturation.
module tb_uart_cmd_ctrl;

  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_VALID = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       WR_EN, ERR, BUSY;
  logic [3:0] WR_ADDR;
  logic [7:0] WR_DATA, FRAME_CNT, ERR_CNT;
  logic [1:0] DBG_STATE;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .ERR(ERR),
    .BUSY(BUSY), .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT), .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  // ---- monitor: records what the DUT emits ----
  logic [11:0] obs_mem [0:1023];
  int obs_n = 0, wr_seen = 0, err_seen = 0, both_seen = 0;

  always @(negedge CLK) begin
    if (WR_EN) begin
      obs_mem[obs_n] <= {WR_ADDR, WR_DATA};
      obs_n          <= obs_n + 1;
      wr_seen        <= wr_seen + 1;
    end
    if (ERR) err_seen <= err_seen + 1;
    if (WR_EN && ERR) both_seen <= both_seen + 1;
  end

  // ---- scoreboard / model ----
  logic [11:0] exp_q[$];
  int          obs_rd = 0;
  int          tests = 0, fails = 0;
  logic [7:0]  frame_exp = 8'd0, err_exp = 8'd0, last_data = 8'd0;
  logic [3:0]  last_addr = 4'd0;
  int          wr0, err0, both0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_VALID = 1'b1;
    RX_DATA  = b;
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    RX_VALID = 1'b0;
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic snap();
    wr0 = wr_seen; err0 = err_seen; both0 = both_seen;
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    frame_exp = frame_exp + 8'd1;
    last_addr = a;
    last_data = d;
  endtask

  task automatic expect_err();
    if (err_exp != 8'hFF) err_exp = err_exp + 8'd1;
  endtask

  task automatic drain(input string name);
    logic [11:0] e;
    while (obs_rd < obs_n) begin
      if (exp_q.size() == 0) begin
        chk({name, "_unexpected_wr"}, {20'd0, obs_mem[obs_rd]}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        chk({name, "_wr_addr_data"}, {20'd0, obs_mem[obs_rd]}, {20'd0, e});
      end
      obs_rd++;
    end
    chk({name, "_missing_wr"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [31:0] bytes;
    logic        exp_wr;
    logic [3:0]  exp_addr;
    logic [7:0]  exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int first_err;
    vecs[0] = '{32'hA5035C5F, 1'b1, 4'h3, 8'h5C, 1'b0};
    vecs[1] = '{32'hA501FFFF, 1'b0, 4'h0, 8'h00, 1'b1};
    vecs[2] = '{32'hA50FF201, 1'b1, 4'hF, 8'hF2, 1'b0};
    vecs[3] = '{32'h0012A5A5, 1'b0, 4'h0, 8'h00, 1'b1};
    vecs[4] = '{32'hA5100010, 1'b0, 4'h0, 8'h00, 1'b1};
    vecs[5] = '{32'hA5000000, 1'b1, 4'h0, 8'h00, 1'b0};
    vecs[6] = '{32'h11223344, 1'b0, 4'h0, 8'h00, 1'b0};
    vecs[7] = '{32'hA5078087, 1'b1, 4'h7, 8'h80, 1'b0};
    vecs[8] = '{32'hA5078088, 1'b0, 4'h0, 8'h00, 1'b1};

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_wr_en", {31'd0, WR_EN}, 0);
    chk("rst_err", {31'd0, ERR}, 0);
    chk("rst_busy", {31'd0, BUSY}, 0);
    chk("rst_wr_addr_data", {20'd0, WR_ADDR, WR_DATA}, 0);
    chk("rst_counters", {16'd0, FRAME_CNT, ERR_CNT}, 0);
    chk("rst_state", {30'd0, DBG_STATE}, 0);
    RST = 1'b0;

    // frame vector table
    for (int v = 0; v < 9; v++) begin
      snap();
      for (int k = 3; k >= 0; k--) send(vecs[v].bytes[k*8 +: 8]);
      idle(3);
      if (vecs[v].exp_wr) expect_write(vecs[v].exp_addr, vecs[v].exp_data);
      if (vecs[v].exp_err) expect_err();
      chk($sformatf("v%0d_wr_count", v), wr_seen - wr0, {31'd0, vecs[v].exp_wr});
      chk($sformatf("v%0d_err_count", v), err_seen - err0, {31'd0, vecs[v].exp_err});
      chk($sformatf("v%0d_wr_err_overlap", v), both_seen - both0, 0);
      chk($sformatf("v%0d_frame_cnt", v), {24'd0, FRAME_CNT}, {24'd0, frame_exp});
      chk($sformatf("v%0d_err_cnt", v), {24'd0, ERR_CNT}, {24'd0, err_exp});
      chk($sformatf("v%0d_busy", v), {31'd0, BUSY}, 0);
      chk($sformatf("v%0d_hold", v), {20'd0, WR_ADDR, WR_DATA}, {20'd0, last_addr, last_data});
      drain($sformatf("v%0d", v));
    end

    // two frames back to back, second SYNC right after the first CSUM
    snap();
    send(8'hA5); send(8'h02); send(8'h03); send(8'h05);
    send(8'hA5); send(8'h04); send(8'h04); send(8'h08);
    idle(3);
    expect_write(4'h2, 8'h03);
    expect_write(4'h4, 8'h04);
    chk("b2b_wr_count", wr_seen - wr0, 2);
    chk("b2b_err_count", err_seen - err0, 0);
    chk("b2b_frame_cnt", {24'd0, FRAME_CNT}, {24'd0, frame_exp});
    drain("b2b");

    // timeout: SYNC then silence
    snap();
    send(8'hA5);
    @(negedge CLK);
    RX_VALID = 1'b0;
    chk("to_state_addr", {30'd0, DBG_STATE}, 1);
    chk("to_busy_pre", {31'd0, BUSY}, 1);
    first_err = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (ERR && first_err == 0) first_err = i;
      if (first_err != 0) break;
    end
    chk("to_latency", first_err, 16);
    @(negedge CLK);
    #1;
    expect_err();
    chk("to_busy_post", {31'd0, BUSY}, 0);
    chk("to_err_cnt", {24'd0, ERR_CNT}, {24'd0, err_exp});
    chk("to_err_pulses", err_seen - err0, 1);

    // byte on the expiry cycle is processed, timeout does not fire
    snap();
    send(8'hA5);
    @(negedge CLK);
    RX_VALID = 1'b0;
    repeat (14) @(negedge CLK);
    send(8'h06); send(8'h10); send(8'h16);
    idle(3);
    expect_write(4'h6, 8'h10);
    chk("expiry_err_count", err_seen - err0, 0);
    chk("expiry_wr_count", wr_seen - wr0, 1);
    chk("expiry_err_cnt", {24'd0, ERR_CNT}, {24'd0, err_exp});
    drain("expiry");

    // reset between DATA and CSUM bytes
    snap();
    send(8'hA5); send(8'h09); send(8'h11);
    @(negedge CLK);
    RX_VALID = 1'b0;
    RST = 1'b1;
    #1;
    chk("mid_rst_flags", {29'd0, WR_EN, ERR, BUSY}, 0);
    chk("mid_rst_wr_addr_data", {20'd0, WR_ADDR, WR_DATA}, 0);
    chk("mid_rst_counters", {16'd0, FRAME_CNT, ERR_CNT}, 0);
    chk("mid_rst_state", {30'd0, DBG_STATE}, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    frame_exp = 8'd0; err_exp = 8'd0; last_addr = 4'd0; last_data = 8'd0;
    idle(2);
    chk("mid_rst_no_err", err_seen - err0, 0);
    chk("mid_rst_no_wr", wr_seen - wr0, 0);

    // 256 good frames, first one right after reset; counter wraps to 0
    snap();
    for (int f = 0; f < 256; f++) begin
      logic [3:0] a;
      logic [7:0] d;
      a = 4'(f % 16);
      d = 8'((f * 37 + 11) % 256);
      send(8'hA5); send({4'h0, a}); send(d); send({4'h0, a} + d);
      expect_write(a, d);
    end
    idle(3);
    chk("wrap_wr_count", wr_seen - wr0, 256);
    chk("wrap_frame_cnt", {24'd0, FRAME_CNT}, 0);
    chk("wrap_err_count", err_seen - err0, 0);
    drain("wrap");

    // 300 bad frames saturate ERR_CNT
    snap();
    for (int f = 0; f < 300; f++) begin
      send(8'hA5); send(8'h01); send(8'hFF); send(8'hFF);
      expect_err();
    end
    idle(3);
    chk("sat_err_pulses", err_seen - err0, 300);
    chk("sat_err_cnt", {24'd0, ERR_CNT}, 255);
    chk("sat_model", {24'd0, ERR_CNT}, {24'd0, err_exp});
    chk("sat_frame_cnt", {24'd0, FRAME_CNT}, 0);
    chk("sat_no_wr", wr_seen - wr0, 0);
    chk("global_overlap", both_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
